// File: rtl/param_scan_mux_pkg.sv
// param_scan_mux_pkg: mode encodings and the wrapping channel increment shared by the scan mux
package param_scan_mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO = 1'b1;
  function automatic int unsigned next_ch(input int unsigned cur, input int unsigned n);
    return (cur == n - 1) ? 0 : cur + 1;
  endfunction
endpackage

// File: rtl/param_scan_mux_onehot_decoder.sv
// onehot_decoder: N-bit one-hot of sel, all zeros when en is low or sel is out of range
module onehot_decoder #(
  parameter int N = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N-1:0]     oh
);
  for (genvar i = 0; i < N; i++) begin : g_oh
    assign oh[i] = en && (32'(sel) == i);
  end
endmodule

// File: rtl/param_scan_mux.sv
// param_scan_mux: N-channel registered AND-OR mux with manual/auto-scan select, dwell counter and valid/ready output
module param_scan_mux
  import param_scan_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W = $clog2(CHANNELS),
  parameter int DWELL_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      sel_load,
  input  logic [DWELL_W-1:0]        dwell,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_ch,
  output logic [CHANNELS-1:0]       grant_oh,
  output logic                      sel_err
);
  logic [SEL_W-1:0] cur_q, cur_d, out_ch_q, out_ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] mux_d, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, sel_err_q, sel_err_d;
  logic adv, legal, expire;
  always_comb begin
    mux_d = '0;
    for (int k = 0; k < CHANNELS; k++) mux_d = mux_d | (in_data[k*WIDTH +: WIDTH] & {WIDTH{grant_q[k]}});
  end
  always_comb begin
    adv = !out_valid_q || out_ready;
    legal = {1'b0, sel_in} < (SEL_W+1)'(CHANNELS);
    expire = mode == MODE_AUTO && adv && cnt_q == dwell;
    cur_d = sel_load ? (legal ? sel_in : cur_q) : expire ? SEL_W'(next_ch(32'(cur_q), CHANNELS)) : cur_q;
    cnt_d = sel_load ? (legal ? '0 : cnt_q) : mode == MODE_MANUAL ? '0 : !adv ? cnt_q : expire ? '0 : cnt_q + 1'b1;
    sel_err_d = sel_load && !legal;
    out_data_d = adv ? mux_d : out_data_q;
    out_valid_d = adv ? |(in_valid & grant_q) : out_valid_q;
    out_ch_d = adv ? cur_q : out_ch_q;
  end
  onehot_decoder #(.N(CHANNELS), .SEL_W(SEL_W)) u_dec (.sel(cur_d), .en(1'b1), .oh(grant_d));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      cnt_q <= '0;
      grant_q <= CHANNELS'(1);
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      out_ch_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q <= out_ch_d;
      sel_err_q <= sel_err_d;
    end
  end
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch = out_ch_q;
  assign grant_oh = grant_q;
  assign sel_err = sel_err_q;
endmodule

// File: tb/tb_param_scan_mux.sv
// tb_param_scan_mux: directed scoreboard bench for param_scan_mux (4- and 3-channel instances)
module tb_param_scan_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] in_data;
  logic [3:0] in_valid, grant_oh;
  logic mode, sel_load, out_ready, out_valid, sel_err;
  logic [1:0] sel_in, out_ch;
  logic [7:0] dwell, out_data;
  logic [23:0] d3_in_data;
  logic [2:0] d3_in_valid, d3_grant_oh;
  logic d3_mode, d3_sel_load, d3_out_ready, d3_out_valid, d3_sel_err;
  logic [1:0] d3_sel_in, d3_out_ch;
  logic [7:0] d3_dwell, d3_out_data;
  param_scan_mux #(.WIDTH(8), .CHANNELS(4), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .mode(mode),
    .sel_in(sel_in), .sel_load(sel_load), .dwell(dwell), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .grant_oh(grant_oh),
    .sel_err(sel_err)
  );
  param_scan_mux #(.WIDTH(8), .CHANNELS(3), .DWELL_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid), .mode(d3_mode),
    .sel_in(d3_sel_in), .sel_load(d3_sel_load), .dwell(d3_dwell), .out_data(d3_out_data),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_ch(d3_out_ch), .grant_oh(d3_grant_oh),
    .sel_err(d3_sel_err)
  );
  typedef struct {
    logic [7:0] d;
    logic [1:0] c;
    logic v;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d, input logic [1:0] c, input logic v);
    exp_t e;
    e.d = d;
    e.c = c;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, out_data, e.d);
      chk({tag, "_ch"}, out_ch, e.c);
      chk({tag, "_valid"}, out_valid, e.v);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    in_valid = 4'hF;
    mode = 1'b0;
    sel_in = 2'd0;
    sel_load = 1'b0;
    dwell = 8'd0;
    out_ready = 1'b1;
    d3_in_data = {8'h33, 8'h22, 8'h11};
    d3_in_valid = 3'b111;
    d3_mode = 1'b0;
    d3_sel_in = 2'd0;
    d3_sel_load = 1'b0;
    d3_dwell = 8'd0;
    d3_out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_grant", grant_oh, 4'b0001);
    chk("rst_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("pre_valid", out_valid, 1'b1);
    chk("pre_data", out_data, 8'hA0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ch", out_ch, 2'd0);
    chk("mid_rst_grant", grant_oh, 4'b0001);
    chk("mid_rst_err", sel_err, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 1'b1);
    sel_in = 2'd2;
    sel_load = 1'b1;
    push(8'hC2, 2'd2, 1'b1);
    tick();
    sel_load = 1'b0;
    chk("sel_grant", grant_oh, 4'b0100);
    chk("sel_ch_lag", out_ch, 2'd0);
    tick();
    pop_chk("sel_out");
    mode = 1'b1;
    dwell = 8'd2;
    sel_in = 2'd0;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    for (int k = 0; k < 13; k++) begin
      logic [1:0] c;
      c = 2'((k / 3) % 4);
      push(8'hA0 + 8'h11 * {6'd0, c}, c, 1'b1);
    end
    for (int k = 0; k < 13; k++) begin
      tick();
      pop_chk("scan");
    end
    dwell = 8'd0;
    sel_in = 2'd1;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    tick();
    chk("bp_pre_ch", out_ch, 2'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_ch", out_ch, 2'd1);
      chk("bp_data", out_data, 8'hB1);
      chk("bp_grant", grant_oh, 4'b0100);
    end
    out_ready = 1'b1;
    push(8'hC2, 2'd2, 1'b1);
    push(8'hD3, 2'd3, 1'b1);
    push(8'hA0, 2'd0, 1'b1);
    repeat (3) begin
      tick();
      pop_chk("bp_resume");
    end
    dwell = 8'd2;
    sel_in = 2'd0;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    repeat (2) tick();
    chk("exp_pre", grant_oh, 4'b0001);
    sel_in = 2'd3;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    chk("exp_load", grant_oh, 4'b1000);
    push(8'hD3, 2'd3, 1'b1);
    tick();
    pop_chk("exp_out");
    tick();
    chk("exp_hold", grant_oh, 4'b1000);
    tick();
    chk("exp_wrap", grant_oh, 4'b0001);
    mode = 1'b0;
    in_valid = 4'b1101;
    sel_in = 2'd1;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    chk("inv_grant", grant_oh, 4'b0010);
    push(8'hB1, 2'd1, 1'b0);
    tick();
    pop_chk("inv");
    in_data[15:8] = 8'h55;
    push(8'h55, 2'd1, 1'b0);
    tick();
    pop_chk("inv_track");
    sel_in = 2'd0;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    chk("inv_stay", out_valid, 1'b0);
    push(8'hA0, 2'd0, 1'b1);
    tick();
    pop_chk("valid_back");
    d3_sel_in = 2'd1;
    d3_sel_load = 1'b1;
    tick();
    d3_sel_load = 1'b0;
    chk("c3_grant", d3_grant_oh, 3'b010);
    chk("c3_err_idle", d3_sel_err, 1'b0);
    d3_sel_in = 2'd3;
    d3_sel_load = 1'b1;
    tick();
    d3_sel_load = 1'b0;
    chk("c3_err_pulse", d3_sel_err, 1'b1);
    chk("c3_err_grant", d3_grant_oh, 3'b010);
    tick();
    chk("c3_err_clear", d3_sel_err, 1'b0);
    chk("c3_err_grant2", d3_grant_oh, 3'b010);
    chk("c3_err_ch", d3_out_ch, 2'd1);
    d3_mode = 1'b1;
    d3_dwell = 8'd0;
    tick();
    chk("c3_step", d3_grant_oh, 3'b100);
    tick();
    chk("c3_wrap", d3_grant_oh, 3'b001);
    chk("c3_wrap_ch", d3_out_ch, 2'd2);
    chk("c3_wrap_data", d3_out_data, 8'h33);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_scan_mux.md
Name: param_scan_mux

Overview:
- Parametrised N-channel, W-bit registered multiplexer.
- Channel select is decoded to a registered one-hot grant.
- Replaces shared-net tristate multiplexing with an AND-OR datapath; no Z values anywhere.
- Adds a manual/auto-scan mode with a programmable dwell counter and a valid/ready output stage. Used wherever several sources share one downstream consumer.

Parameters:
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of inputs, must be at least 2
- SEL_W, $clog2(CHANNELS), select width (derived, do not override)
- DWELL_W, 8, width of dwell count

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- in_data  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel data-valid
- mode  in  1  0 = manual, 1 = auto scan
- sel_in  in  SEL_W  channel to load
- sel_load  in  1  single-cycle load strobe for sel_in
- dwell  in  DWELL_W  auto mode: cycles spent per channel = dwell+1
- out_data  out  WIDTH  registered selected data
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts the word
- out_ch  out  SEL_W  channel index that out_data came from
- grant_oh  out  CHANNELS  one-hot of current channel (cur)
- sel_err  out  1  one-cycle pulse: sel_load with sel_in >= CHANNELS

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets:
  - cur = 0, dwell_cnt = 0
  - out_data = 0, out_valid = 0, out_ch = 0
  - grant_oh = 1 (channel 0)
  - sel_err = 0
- Reset mid-operation discards the held output word.
- Datapath: mux_d = OR over k of (in_data[k] AND replicate(grant_oh[k])). grant_oh is registered and exactly one-hot at all times.
- Output stage, evaluated each cycle with adv = !out_valid || out_ready:
  - adv=1: out_valid <= in_valid[cur]; out_data <= mux_d; out_ch <= cur.
  - adv=0 (stall): out_data, out_valid and out_ch hold.
- Latency: a change of cur appears on out_* one cycle after grant_oh updates, so two edges after sel_load.
- Select update (priority order):
  1. sel_load=1 and sel_in < CHANNELS: cur <= sel_in; dwell_cnt <= 0. Applies in either mode, ignores stall.
  2. sel_load=1 and sel_in >= CHANNELS: cur unchanged; sel_err = 1 next cycle for one cycle.
  3. mode=1 and adv=1:
     - dwell_cnt == dwell: cur <= (cur == CHANNELS-1) ? 0 : cur+1; dwell_cnt <= 0.
     - otherwise dwell_cnt increments.
  4. mode=1 and adv=0: dwell_cnt and cur freeze. A stalled word is never skipped past.
  5. mode=0: cur holds; dwell_cnt <= 0.
- dwell = 0 in auto mode: advance on every unstalled cycle.
- Wrap-around: non-power-of-2 CHANNELS wraps at CHANNELS-1, never reaching an illegal index.
- Switching mode 0→1: counting starts from dwell_cnt = 0 on the current channel.
- Switching mode 1→0: cur stays where the scan left it.
- Changing dwell mid-scan: takes effect on the next compare. If dwell_cnt already exceeds the new dwell, counting continues and wraps through 2^DWELL_W before the advance.
- grant_oh is updated in the same edge as cur (grant_oh = decode of next cur).

Decomposition:
- Package param_scan_mux_pkg holds:
  - MODE_MANUAL = 1'b0, MODE_AUTO = 1'b1
  - a function next_ch(cur, n) implementing the wrap increment
- One sub-module, onehot_decoder:
  - parameters N, SEL_W
  - inputs: sel, en
  - output: N-bit one-hot, all zeros when en=0 or sel >= N
  - used combinationally on the next-cur value, result registered in param_scan_mux.

Test Plan:
- Reset then manual select: rst_n low mid-run with out_valid=1; expect every output at its reset value immediately, grant_oh=0001.
  - After release, with CHANNELS=4, WIDTH=8, in_data={8'hD3,8'hC2,8'hB1,8'hA0}, all valid, out_ready=1, sel_load with sel_in=2 → grant_oh=0100 next edge; out_data=8'hC2, out_ch=2 on the following edge.
- Illegal select: CHANNELS=3, sel_in=3 with sel_load → sel_err single pulse, cur and grant_oh unchanged.
- Auto scan with dwell=2, out_ready=1 → each channel held for 3 cycles; sequence 0,1,2,3,0 on out_ch; wraps 3→0.
- Backpressure: auto mode, dwell=0, out_ready=0 for 5 cycles → out_data/out_ch frozen, cur frozen.
  - On out_ready=1 the held word is accepted and the scan resumes at the next channel with none skipped.
- Invalid source: in_valid[1]=0, manual cur=1 → out_valid=0 while out_data still tracks in_data[1].
  - Switching to channel 0 with in_valid[0]=1 → out_valid=1 after two edges.
- sel_load in auto mode on the same cycle as a dwell expiry → sel_in wins and dwell_cnt restarts at 0.
